// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: DATA_BITS data bits LSB first, optional parity, 1 or 2 stop bits,
// start-glitch rejection and a valid/ready output register with sticky overrun.
module uart_rx_cfg #(
  parameter int BAUDRATE  = 104,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 perr,
  output logic                 ferr,
  output logic                 ovr
);

  localparam int CW = $clog2(BAUDRATE);
  // Expiry is at zero, so loads are one less than the wanted distance to the next sample.
  localparam logic [CW-1:0] HALF_LOAD = CW'(BAUDRATE / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(BAUDRATE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_meta_q, rx_s_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 fperr_q, fperr_d;
  logic                 fferr_q, fferr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  logic tick, commit, commit_ferr, accept;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    fperr_d     = fperr_q;
    fferr_d     = fferr_q;
    data_d      = data_q;
    valid_d     = valid_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    ovr_d       = ovr_q;
    commit      = 1'b0;
    commit_ferr = fferr_q;
    tick        = (cnt_q == '0);
    accept      = valid_q & ready;

    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          cnt_d   = HALF_LOAD;
          state_d = S_START;
        end
      end
      S_START: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rx_s_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DATA;
          cnt_d   = FULL_LOAD;
          bit_d   = '0;
          fperr_d = 1'b0;
          fferr_d = 1'b0;
        end
      end
      S_DATA: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          cnt_d   = FULL_LOAD;
          if (bit_q == 4'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          fperr_d = (PARITY == 2) ? ((^shift_q ^ rx_s_q) != 1'b0)
                                  : ((^shift_q ^ rx_s_q) != 1'b1);
          cnt_d   = FULL_LOAD;
          bit_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          commit_ferr = fferr_q | ~rx_s_q;
          fferr_d     = commit_ferr;
          cnt_d       = FULL_LOAD;
          if (bit_q == 4'(STOP_BITS - 1)) begin
            commit  = 1'b1;
            state_d = commit_ferr ? S_WAIT_HIGH : S_IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_WAIT_HIGH: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A commit coinciding with an accept replaces the word without counting as overrun.
    if (commit) begin
      if (!valid_q || accept) begin
        data_d  = shift_q;
        perr_d  = fperr_q;
        ferr_d  = commit_ferr;
        valid_d = 1'b1;
        if (accept) ovr_d = 1'b0;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (accept) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      fperr_q   <= 1'b0;
      fferr_q   <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      fperr_q   <= fperr_d;
      fferr_q   <= fferr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign perr  = perr_q;
  assign ferr  = ferr_q;
  assign ovr   = ovr_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1 instance and an 8E2 instance, each fed by a bit-level frame
// generator, with expected words queued at send time and popped by per-instance monitors.
module tb_uart_rx_cfg;

  localparam int B   = 16;
  localparam int K_N = 2 + B / 2 + (8 + 0 + 1) * B;
  localparam int K_P = 2 + B / 2 + (8 + 1 + 2) * B;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rx_n, rx_p, ready_n, ready_p;
  logic [7:0] data_n, data_p;
  logic       valid_n, perr_n, ferr_n, ovr_n;
  logic       valid_p, perr_p, ferr_p, ovr_p;

  uart_rx_cfg #(.BAUDRATE(B), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n (
    .clk(clk), .rst(rst), .rx(rx_n), .data(data_n), .valid(valid_n),
    .ready(ready_n), .perr(perr_n), .ferr(ferr_n), .ovr(ovr_n));

  uart_rx_cfg #(.BAUDRATE(B), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_p (
    .clk(clk), .rst(rst), .rx(rx_p), .data(data_p), .valid(valid_p),
    .ready(ready_p), .perr(perr_p), .ferr(ferr_p), .ovr(ovr_p));

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       ov;
  } exp_t;

  exp_t q_n[$];
  exp_t q_p[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drv(input int which, input logic v);
    if (which == 0) rx_n = v;
    else rx_p = v;
  endtask

  // Drives one frame on the chosen line; instance 1 gets a parity bit and two stop bits.
  task automatic send(input int which, input logic [7:0] d, input logic pbit,
                      input logic [1:0] stops, input bit keep_low);
    int nstop;
    nstop = (which == 0) ? 1 : 2;
    drv(which, 1'b0);
    cyc(B);
    for (int i = 0; i < 8; i++) begin
      drv(which, d[i]);
      cyc(B);
    end
    if (which == 1) begin
      drv(which, pbit);
      cyc(B);
    end
    for (int i = 0; i < nstop; i++) begin
      drv(which, stops[i]);
      cyc(B);
    end
    if (!keep_low) drv(which, 1'b1);
  endtask

  // Even parity: an error whenever the total count of ones over data and parity is odd.
  function automatic exp_t model(input int which, input logic [7:0] d, input logic pbit,
                                 input logic [1:0] stops, input logic ov);
    exp_t e;
    e.d  = d;
    e.pe = (which == 1) ? ((($countones(d) + int'(pbit)) % 2) != 0) : 1'b0;
    e.fe = (which == 0) ? !stops[0] : !(stops[0] && stops[1]);
    e.ov = ov;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && valid_n && ready_n) begin
      if (q_n.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL n_unexpected_word: got data 0x%0h expected no word", data_n);
      end else begin
        e = q_n.pop_front();
        check("n_data", 32'(data_n), 32'(e.d));
        check("n_perr", 32'(perr_n), 32'(e.pe));
        check("n_ferr", 32'(ferr_n), 32'(e.fe));
        check("n_ovr", 32'(ovr_n), 32'(e.ov));
        $display("n word data=0x%02h perr=%0d ferr=%0d ovr=%0d", data_n, perr_n, ferr_n, ovr_n);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && valid_p && ready_p) begin
      if (q_p.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL p_unexpected_word: got data 0x%0h expected no word", data_p);
      end else begin
        e = q_p.pop_front();
        check("p_data", 32'(data_p), 32'(e.d));
        check("p_perr", 32'(perr_p), 32'(e.pe));
        check("p_ferr", 32'(ferr_p), 32'(e.fe));
        check("p_ovr", 32'(ovr_p), 32'(e.ov));
        $display("p word data=0x%02h perr=%0d ferr=%0d ovr=%0d", data_p, perr_p, ferr_p, ovr_p);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat;
    bit         p_done;
    logic [7:0] rd_n, rd_p;
    logic [1:0] st_n, st_p;
    logic       pb;
    int         gap_n, gap_p;

    rst = 1'b1; rx_n = 1'b1; rx_p = 1'b1; ready_n = 1'b1; ready_p = 1'b1;
    p_done = 1'b0;
    cyc(3);
    check("rst_n_valid", 32'(valid_n), 0);
    check("rst_n_data", 32'(data_n), 0);
    check("rst_n_flags", {29'd0, perr_n, ferr_n, ovr_n}, 0);
    check("rst_p_valid", 32'(valid_p), 0);
    check("rst_p_flags", {29'd0, perr_p, ferr_p, ovr_p}, 0);
    rst = 1'b0;
    cyc(5);

    // 8N1 pair with latency measured from the cycle rx falls
    q_n.push_back(model(0, 8'h55, 1'b0, 2'b11, 1'b0));
    lat = 0;
    fork
      send(0, 8'h55, 1'b0, 2'b11, 1'b0);
      begin
        while (lat < 400 && !valid_n) begin
          @(posedge clk);
          lat++;
          #1;
        end
        check("n_valid_latency", 32'(lat), 32'(K_N + 1));
      end
    join
    cyc(4 * B);
    q_n.push_back(model(0, 8'h4B, 1'b0, 2'b11, 1'b0));
    send(0, 8'h4B, 1'b0, 2'b11, 1'b0);
    cyc(2 * B);

    // even parity, with and without a parity error
    q_p.push_back(model(1, 8'hA5, 1'b1, 2'b11, 1'b0));
    send(1, 8'hA5, 1'b1, 2'b11, 1'b0);
    cyc(B);
    q_p.push_back(model(1, 8'hA5, 1'b0, 2'b11, 1'b0));
    send(1, 8'hA5, 1'b0, 2'b11, 1'b0);
    cyc(2 * B);

    // framing error followed by a long break gives exactly one word
    q_n.push_back(model(0, 8'h3C, 1'b0, 2'b00, 1'b0));
    send(0, 8'h3C, 1'b0, 2'b00, 1'b1);
    cyc(20 * B);
    rx_n = 1'b1;
    cyc(2 * B);
    q_n.push_back(model(0, 8'h81, 1'b0, 2'b11, 1'b0));
    send(0, 8'h81, 1'b0, 2'b11, 1'b0);
    cyc(2 * B);

    // short start glitch
    rx_n = 1'b0;
    cyc(B / 4);
    rx_n = 1'b1;
    cyc(12 * B);
    check("glitch_no_valid", 32'(valid_n), 0);
    q_n.push_back(model(0, 8'h7E, 1'b0, 2'b11, 1'b0));
    send(0, 8'h7E, 1'b0, 2'b11, 1'b0);
    cyc(2 * B);

    // overrun with ready held low
    ready_n = 1'b0;
    q_n.push_back(model(0, 8'h11, 1'b0, 2'b11, 1'b1));
    send(0, 8'h11, 1'b0, 2'b11, 1'b0);
    cyc(B);
    send(0, 8'h22, 1'b0, 2'b11, 1'b0);
    cyc(2 * B);
    check("ovr_held_valid", 32'(valid_n), 1);
    check("ovr_held_data", 32'(data_n), 32'h11);
    check("ovr_set", 32'(ovr_n), 1);
    ready_n = 1'b1;
    cyc(1);
    ready_n = 1'b0;
    check("ovr_accept_valid", 32'(valid_n), 0);
    check("ovr_accept_clear", 32'(ovr_n), 0);

    // accept lands on the same edge as the next commit
    q_n.push_back(model(0, 8'h33, 1'b0, 2'b11, 1'b0));
    send(0, 8'h33, 1'b0, 2'b11, 1'b0);
    cyc(B);
    q_n.push_back(model(0, 8'h44, 1'b0, 2'b11, 1'b0));
    fork
      send(0, 8'h44, 1'b0, 2'b11, 1'b0);
      begin
        cyc(K_N);
        ready_n = 1'b1;
        cyc(1);
        ready_n = 1'b0;
        check("same_cycle_valid", 32'(valid_n), 1);
        check("same_cycle_data", 32'(data_n), 32'h44);
        check("same_cycle_ovr", 32'(ovr_n), 0);
      end
    join
    ready_n = 1'b1;
    cyc(2);

    // reset in the middle of data bit 3, held until the frame has passed
    fork
      send(0, 8'hF0, 1'b0, 2'b11, 1'b0);
      begin
        cyc(4 * B + B / 2);
        rst = 1'b1;
      end
    join
    cyc(B);
    check("midrst_valid", 32'(valid_n), 0);
    check("midrst_data", 32'(data_n), 0);
    check("midrst_flags", {29'd0, perr_n, ferr_n, ovr_n}, 0);
    rst = 1'b0;
    cyc(B);
    q_n.push_back(model(0, 8'h0F, 1'b0, 2'b11, 1'b0));
    send(0, 8'h0F, 1'b0, 2'b11, 1'b0);
    cyc(2 * B);

    // randomized traffic on both instances concurrently
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          rd_n  = 8'($urandom);
          st_n  = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b11;
          gap_n = $urandom_range(0, 2) + (st_n[0] ? 0 : 1);
          q_n.push_back(model(0, rd_n, 1'b0, st_n, 1'b0));
          send(0, rd_n, 1'b0, st_n, 1'b0);
          cyc(gap_n * B);
        end
      end
      begin
        for (int i = 0; i < 20; i++) begin
          rd_p  = 8'($urandom);
          pb    = 1'($urandom_range(0, 1));
          st_p  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
          gap_p = $urandom_range(0, 2) + ((st_p == 2'b11) ? 0 : 1);
          q_p.push_back(model(1, rd_p, pb, st_p, 1'b0));
          send(1, rd_p, pb, st_p, 1'b0);
          cyc(gap_p * B);
        end
        p_done = 1'b1;
      end
      begin
        while (!p_done) begin
          ready_p = 1'($urandom_range(0, 1));
          cyc(1);
        end
        ready_p = 1'b1;
      end
    join

    cyc(4 * B);
    check("n_queue_drained", 32'(q_n.size()), 0);
    check("p_queue_drained", 32'(q_p.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
